// File: rtl/cfg_switch_matrix_if.sv
// cfg_switch_matrix_if
//   Bundles the configuration command port, the READ response and the routed
//   wire bus of cfg_switch_matrix.
//   master : drives cfg_valid/cfg_op/cfg_wire/cfg_sel and wire_in,
//            observes cfg_ready/cfg_err/rsp_valid/rsp_sel/wire_out/wire_oe
//   slave  : the switch matrix itself (mirror directions)
interface cfg_switch_matrix_if #(
  parameter int N_WIRES = 18,
  parameter int SEL_W   = 5
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [1:0]         cfg_op;
  logic [SEL_W-1:0]   cfg_wire;
  logic [SEL_W-1:0]   cfg_sel;
  logic               cfg_err;
  logic               rsp_valid;
  logic [SEL_W-1:0]   rsp_sel;
  logic [N_WIRES-1:0] wire_in;
  logic [N_WIRES-1:0] wire_out;
  logic [N_WIRES-1:0] wire_oe;

  modport master (
    output cfg_valid, cfg_op, cfg_wire, cfg_sel, wire_in,
    input  cfg_ready, cfg_err, rsp_valid, rsp_sel, wire_out, wire_oe
  );

  modport slave (
    input  cfg_valid, cfg_op, cfg_wire, cfg_sel, wire_in,
    output cfg_ready, cfg_err, rsp_valid, rsp_sel, wire_out, wire_oe
  );
endinterface

// File: rtl/cfg_switch_matrix.sv
// cfg_switch_matrix
//   Run-time configurable routing switch. Each of N_WIRES outputs is driven
//   from one selected input wire (select 1..N_WIRES) or left undriven
//   (select 0). Commands load a shadow table; COMMIT copies the whole shadow
//   table into the live table in a single edge, so routing never shows a
//   partially written pattern. CLEAR zeroes the shadow table one entry per
//   cycle without touching live routing.
// Ports
//   clk  : fabric clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : slave side of cfg_switch_matrix_if (command port, READ response,
//          wire_in / wire_out / wire_oe)
module cfg_switch_matrix #(
  parameter int N_WIRES = 18,
  parameter int SEL_W   = 5
) (
  input  logic                clk,
  input  logic                rst,
  cfg_switch_matrix_if.slave  bus
);

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_COMMIT = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_READ   = 2'b11;

  localparam logic [SEL_W-1:0] MAX_IDX = SEL_W'(N_WIRES);
  localparam logic [SEL_W-1:0] ONE     = SEL_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_COMMIT
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [SEL_W-1:0] shadow [1:N_WIRES];
  logic [SEL_W-1:0] active [1:N_WIRES];
  logic [SEL_W-1:0] clr_idx;
  logic             wire_ok;
  logic             write_ok;
  logic             do_write;
  logic             do_read;
  logic             do_err;
  logic [N_WIRES-1:0] oe_vec;
  logic [N_WIRES-1:0] out_vec;

  // Command decode and next-state logic. Commands are only accepted in IDLE;
  // a wire may never select itself, which is the only loop we reject.
  always_comb begin
    state_nxt     = state;
    bus.cfg_ready = 1'b0;
    do_write      = 1'b0;
    do_read       = 1'b0;
    do_err        = 1'b0;
    wire_ok       = (bus.cfg_wire != '0) && (bus.cfg_wire <= MAX_IDX);
    write_ok      = wire_ok && (bus.cfg_sel <= MAX_IDX) &&
                    (bus.cfg_sel != bus.cfg_wire);
    case (state)
      ST_IDLE: begin
        bus.cfg_ready = 1'b1;
        if (bus.cfg_valid) begin
          case (bus.cfg_op)
            OP_WRITE: begin
              do_write = write_ok;
              do_err   = !write_ok;
            end
            OP_READ: begin
              do_read = wire_ok;
              do_err  = !wire_ok;
            end
            OP_COMMIT: state_nxt = ST_COMMIT;
            OP_CLEAR:  state_nxt = ST_CLEAR;
            default:   state_nxt = ST_IDLE;
          endcase
        end
      end
      ST_CLEAR: begin
        if (clr_idx == MAX_IDX) state_nxt = ST_IDLE;
      end
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // CLEAR walks k = 1..N_WIRES; the counter is parked at 1 while idle so it
  // is ready the moment CLEAR starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    clr_idx <= ONE;
    else if (state == ST_CLEAR) clr_idx <= clr_idx + ONE;
    else                        clr_idx <= ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i <= N_WIRES; i++) shadow[i] <= '0;
    end else if (do_write) begin
      shadow[bus.cfg_wire] <= bus.cfg_sel;
    end else if (state == ST_CLEAR) begin
      shadow[clr_idx] <= '0;
    end
  end

  // The live table is copied as a whole at the end of the COMMIT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i <= N_WIRES; i++) active[i] <= '0;
    end else if (state == ST_COMMIT) begin
      for (int i = 1; i <= N_WIRES; i++) active[i] <= shadow[i];
    end
  end

  // READ samples the shadow value present at acceptance, so a WRITE in the
  // previous cycle is already visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.cfg_err   <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_sel   <= '0;
    end else begin
      bus.cfg_err   <= do_err;
      bus.rsp_valid <= do_read;
      if (do_read) bus.rsp_sel <= shadow[bus.cfg_wire];
    end
  end

  // Purely combinational crossbar; select value s routes wire_in bit s-1.
  for (genvar g = 1; g <= N_WIRES; g++) begin : g_route
    assign oe_vec[g-1]  = (active[g] != '0);
    assign out_vec[g-1] = (active[g] != '0) ? bus.wire_in[active[g] - ONE] : 1'b0;
  end

  assign bus.wire_oe  = oe_vec;
  assign bus.wire_out = out_vec;

endmodule

// File: tb/tb_cfg_switch_matrix.sv
// tb_cfg_switch_matrix
//   Drives cfg_switch_matrix through scenario tasks and compares against a
//   table-level model: shadow_m/active_m arrays updated by command rules.
module tb_cfg_switch_matrix;
  localparam int N  = 18;
  localparam int SW = 5;

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_COMMIT = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_READ   = 2'b11;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cfg_switch_matrix_if #(.N_WIRES(N), .SEL_W(SW)) bus ();

  cfg_switch_matrix #(.N_WIRES(N), .SEL_W(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  int shadow_m [1:N];
  int active_m [1:N];

  // Reference model: tables of select values.
  function automatic void model_reset();
    for (int i = 1; i <= N; i++) begin
      shadow_m[i] = 0;
      active_m[i] = 0;
    end
  endfunction

  function automatic void model_commit();
    for (int i = 1; i <= N; i++) active_m[i] = shadow_m[i];
  endfunction

  function automatic void model_cmd(input logic [1:0] op, input int w, input int s,
                                    output logic eerr, output logic erv,
                                    output int ers, output int ebusy);
    eerr = 1'b0; erv = 1'b0; ers = 0; ebusy = 0;
    case (op)
      OP_WRITE: begin
        if (w >= 1 && w <= N && s >= 0 && s <= N && s != w) shadow_m[w] = s;
        else eerr = 1'b1;
      end
      OP_READ: begin
        if (w >= 1 && w <= N) begin erv = 1'b1; ers = shadow_m[w]; end
        else eerr = 1'b1;
      end
      OP_COMMIT: ebusy = 1;
      default: begin
        ebusy = N;
        for (int i = 1; i <= N; i++) shadow_m[i] = 0;
      end
    endcase
  endfunction

  function automatic void exp_route(input logic [N-1:0] win,
                                    output logic [N-1:0] eo, output logic [N-1:0] ee);
    eo = '0; ee = '0;
    for (int i = 1; i <= N; i++) begin
      if (active_m[i] != 0) begin
        ee[i-1] = 1'b1;
        eo[i-1] = win[active_m[i]-1];
      end
    end
  endfunction

  // Present one command, hold it until accepted, return the outputs seen
  // one cycle after the acceptance edge.
  task automatic send_cmd(input logic [1:0] op, input int w, input int s,
                          output logic err, output logic rv, output logic [SW-1:0] rs);
    int n;
    n = 0;
    bus.cfg_valid = 1'b1;
    bus.cfg_op    = op;
    bus.cfg_wire  = SW'(w);
    bus.cfg_sel   = SW'(s);
    while (bus.cfg_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      tests_run++; tests_failed++;
      $display("[TB] FAIL accept_timeout: ready stayed %b, required 1", bus.cfg_ready);
    end
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
    err = bus.cfg_err;
    rv  = bus.rsp_valid;
    rs  = bus.rsp_sel;
  endtask

  task automatic wait_ready(output int busy);
    busy = 0;
    while (bus.cfg_ready !== 1'b1 && busy < 100) begin
      @(posedge clk); #1;
      busy++;
    end
  endtask

  task automatic test_reset();
    logic err, rv; logic [SW-1:0] rs; int busy;
    logic [N-1:0] eo, ee;
    bus.cfg_valid = 1'b0; bus.cfg_op = '0; bus.cfg_wire = '0; bus.cfg_sel = '0;
    bus.wire_in = 18'($urandom());
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    if (bus.cfg_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_ready: got %b required 1", bus.cfg_ready); end
    tests_run++;
    if (bus.wire_oe !== '0) begin tests_failed++; $display("[TB] FAIL reset_oe: got %h required 0", bus.wire_oe); end
    tests_run++;
    if (bus.wire_out !== '0) begin tests_failed++; $display("[TB] FAIL reset_out: got %h required 0", bus.wire_out); end
    tests_run++;
    if (bus.cfg_err !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_sel !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_rsp: got err=%b rv=%b sel=%0d required 0/0/0", bus.cfg_err, bus.rsp_valid, bus.rsp_sel);
    end
    tests_run++;
    rst = 1'b0;
    // Load something live, then reset in the middle of a CLEAR.
    send_cmd(OP_WRITE, 4, 9, err, rv, rs);
    send_cmd(OP_COMMIT, 0, 0, err, rv, rs);
    wait_ready(busy);
    send_cmd(OP_CLEAR, 0, 0, err, rv, rs);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    exp_route(bus.wire_in, eo, ee);
    if (bus.cfg_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_midclear_ready: got %b required 1", bus.cfg_ready); end
    tests_run++;
    if (bus.wire_oe !== ee) begin tests_failed++; $display("[TB] FAIL reset_midclear_oe: got %h required %h", bus.wire_oe, ee); end
    tests_run++;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      int w;
      w = (k == 0) ? 4 : int'($urandom_range(1, N));
      send_cmd(OP_READ, w, 0, err, rv, rs);
      if (rv !== 1'b1 || rs !== '0) begin
        tests_failed++;
        $display("[TB] FAIL reset_read w%0d: got rv=%b sel=%0d required rv=1 sel=0", w, rv, rs);
      end
      tests_run++;
    end
  endtask

  task automatic test_route();
    logic err, rv; logic [SW-1:0] rs; int busy;
    logic eerr, erv; int ers, ebusy;
    model_cmd(OP_WRITE, 3, 7, eerr, erv, ers, ebusy);
    send_cmd(OP_WRITE, 3, 7, err, rv, rs);
    if (err !== eerr) begin tests_failed++; $display("[TB] FAIL route_write_err: got %b required %b", err, eerr); end
    tests_run++;
    bus.wire_in = 18'h00040;
    #1;
    if (bus.wire_oe !== 18'h0) begin tests_failed++; $display("[TB] FAIL route_precommit_oe: got %h required 0", bus.wire_oe); end
    tests_run++;
    send_cmd(OP_COMMIT, 0, 0, err, rv, rs);
    if (bus.wire_oe !== 18'h0) begin tests_failed++; $display("[TB] FAIL route_commit_cycle_oe: got %h required 0", bus.wire_oe); end
    tests_run++;
    wait_ready(busy);
    model_commit();
    if (busy != 1) begin tests_failed++; $display("[TB] FAIL route_commit_busy: got %0d required 1", busy); end
    tests_run++;
    if (bus.wire_oe !== 18'h00004 || bus.wire_out !== 18'h00004) begin
      tests_failed++;
      $display("[TB] FAIL route_live: got oe=%h out=%h required oe=00004 out=00004", bus.wire_oe, bus.wire_out);
    end
    tests_run++;
  endtask

  task automatic test_illegal();
    logic [1:0] ops [4];
    int ws [4];
    int ss [4];
    logic err, rv; logic [SW-1:0] rs;
    logic eerr, erv; int ers, ebusy;
    ops = '{OP_WRITE, OP_WRITE, OP_WRITE, OP_READ};
    ws  = '{5, 0, 2, 25};
    ss  = '{5, 1, 19, 0};
    for (int k = 0; k < 4; k++) begin
      model_cmd(ops[k], ws[k], ss[k], eerr, erv, ers, ebusy);
      send_cmd(ops[k], ws[k], ss[k], err, rv, rs);
      if (err !== eerr || rv !== erv) begin
        tests_failed++;
        $display("[TB] FAIL illegal_%0d: got err=%b rv=%b required err=%b rv=%b", k, err, rv, eerr, erv);
      end
      tests_run++;
      @(posedge clk); #1;
      if (bus.cfg_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL illegal_selfclear_%0d: got %b required 0", k, bus.cfg_err); end
      tests_run++;
    end
    for (int k = 0; k < 3; k++) begin
      int w;
      w = (k == 0) ? 5 : ((k == 1) ? 2 : 3);
      model_cmd(OP_READ, w, 0, eerr, erv, ers, ebusy);
      send_cmd(OP_READ, w, 0, err, rv, rs);
      if (rv !== erv || int'(rs) != ers) begin
        tests_failed++;
        $display("[TB] FAIL illegal_shadow w%0d: got rv=%b sel=%0d required rv=%b sel=%0d", w, rv, rs, erv, ers);
      end
      tests_run++;
    end
  endtask

  task automatic test_atomicity();
    logic err, rv; logic [SW-1:0] rs; int busy;
    logic eerr, erv; int ers, ebusy;
    logic [N-1:0] eo, ee;
    model_cmd(OP_WRITE, 1, 2, eerr, erv, ers, ebusy);
    send_cmd(OP_WRITE, 1, 2, err, rv, rs);
    send_cmd(OP_COMMIT, 0, 0, err, rv, rs);
    wait_ready(busy);
    model_commit();
    bus.wire_in = 18'($urandom()) | 18'h00002;
    model_cmd(OP_WRITE, 1, 4, eerr, erv, ers, ebusy);
    send_cmd(OP_WRITE, 1, 4, err, rv, rs);
    model_cmd(OP_WRITE, 6, 1, eerr, erv, ers, ebusy);
    send_cmd(OP_WRITE, 6, 1, err, rv, rs);
    exp_route(bus.wire_in, eo, ee);
    if (bus.wire_oe !== ee || bus.wire_out !== eo) begin
      tests_failed++;
      $display("[TB] FAIL atomic_old: got oe=%h out=%h required oe=%h out=%h", bus.wire_oe, bus.wire_out, ee, eo);
    end
    tests_run++;
    send_cmd(OP_COMMIT, 0, 0, err, rv, rs);
    exp_route(bus.wire_in, eo, ee);
    if (bus.wire_oe !== ee || bus.wire_out !== eo) begin
      tests_failed++;
      $display("[TB] FAIL atomic_commit_cycle: got oe=%h out=%h required oe=%h out=%h", bus.wire_oe, bus.wire_out, ee, eo);
    end
    tests_run++;
    wait_ready(busy);
    model_commit();
    exp_route(bus.wire_in, eo, ee);
    if (bus.wire_oe !== ee || bus.wire_out !== eo) begin
      tests_failed++;
      $display("[TB] FAIL atomic_new: got oe=%h out=%h required oe=%h out=%h", bus.wire_oe, bus.wire_out, ee, eo);
    end
    tests_run++;
  endtask

  task automatic test_clear();
    logic err, rv; logic [SW-1:0] rs; int busy;
    logic eerr, erv; int ers, ebusy;
    logic [N-1:0] eo, ee;
    for (int w = 1; w <= N; w++) begin
      int s;
      s = (w % N) + 1;
      model_cmd(OP_WRITE, w, s, eerr, erv, ers, ebusy);
      send_cmd(OP_WRITE, w, s, err, rv, rs);
    end
    send_cmd(OP_COMMIT, 0, 0, err, rv, rs);
    wait_ready(busy);
    model_commit();
    model_cmd(OP_CLEAR, 0, 0, eerr, erv, ers, ebusy);
    send_cmd(OP_CLEAR, 0, 0, err, rv, rs);
    wait_ready(busy);
    if (busy != ebusy) begin tests_failed++; $display("[TB] FAIL clear_busy: got %0d cycles required %0d", busy, ebusy); end
    tests_run++;
    bus.wire_in = 18'($urandom());
    #1;
    exp_route(bus.wire_in, eo, ee);
    if (bus.wire_oe !== ee || bus.wire_out !== eo) begin
      tests_failed++;
      $display("[TB] FAIL clear_live_kept: got oe=%h out=%h required oe=%h out=%h", bus.wire_oe, bus.wire_out, ee, eo);
    end
    tests_run++;
    for (int w = 1; w <= N; w++) begin
      send_cmd(OP_READ, w, 0, err, rv, rs);
      if (rv !== 1'b1 || int'(rs) != shadow_m[w]) begin
        tests_failed++;
        $display("[TB] FAIL clear_read w%0d: got rv=%b sel=%0d required rv=1 sel=%0d", w, rv, rs, shadow_m[w]);
      end
      tests_run++;
    end
    send_cmd(OP_COMMIT, 0, 0, err, rv, rs);
    wait_ready(busy);
    model_commit();
    if (bus.wire_oe !== 18'h0) begin tests_failed++; $display("[TB] FAIL clear_commit_oe: got %h required 0", bus.wire_oe); end
    tests_run++;
  endtask

  task automatic test_back_to_back();
    logic err, rv; logic [SW-1:0] rs; int busy;
    logic eerr, erv; int ers, ebusy;
    logic [N-1:0] eo, ee;
    model_cmd(OP_WRITE, 9, 12, eerr, erv, ers, ebusy);
    send_cmd(OP_WRITE, 9, 12, err, rv, rs);
    model_cmd(OP_READ, 9, 0, eerr, erv, ers, ebusy);
    send_cmd(OP_READ, 9, 0, err, rv, rs);
    if (rv !== 1'b1 || int'(rs) != 12) begin
      tests_failed++;
      $display("[TB] FAIL b2b_read: got rv=%b sel=%0d required rv=1 sel=12", rv, rs);
    end
    tests_run++;
    for (int n = 0; n < 2500; n++) begin
      logic [1:0] op;
      int w, s, pick;
      pick = int'($urandom_range(0, 15));
      op = (pick < 8) ? OP_WRITE : (pick < 12) ? OP_READ : (pick < 15) ? OP_COMMIT : OP_CLEAR;
      w = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(1, N));
      s = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, N));
      bus.wire_in = 18'($urandom());
      model_cmd(op, w, s, eerr, erv, ers, ebusy);
      send_cmd(op, w, s, err, rv, rs);
      if (err !== eerr || rv !== erv || (erv && int'(rs) != ers)) begin
        tests_failed++;
        $display("[TB] FAIL rand_%0d op%0d w%0d s%0d: got err=%b rv=%b sel=%0d required err=%b rv=%b sel=%0d",
                 n, op, w, s, err, rv, rs, eerr, erv, ers);
      end
      tests_run++;
      if (ebusy != 0) begin
        wait_ready(busy);
        if (busy != ebusy) begin tests_failed++; $display("[TB] FAIL rand_busy_%0d: got %0d required %0d", n, busy, ebusy); end
        tests_run++;
        if (op == OP_COMMIT) model_commit();
      end
      exp_route(bus.wire_in, eo, ee);
      if (bus.wire_oe !== ee || bus.wire_out !== eo) begin
        tests_failed++;
        $display("[TB] FAIL rand_route_%0d: got oe=%h out=%h required oe=%h out=%h", n, bus.wire_oe, bus.wire_out, ee, eo);
      end
      tests_run++;
    end
  endtask

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_route();
    test_illegal();
    test_atomicity();
    test_clear();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
